// File: rtl/plab2_mem_domain_responder.sv
// Memory responder for the vc mem req/resp protocol. Words are partitioned by security domain, and
// responses are only shown to the domain that issued them. A single request stage feeds an in-order FIFO.
module plab2_mem_domain_responder #(
   parameter int unsigned p_nwords   = 256,
   parameter int unsigned p_nentries = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [76:0] memreq_msg,
   input  logic        memreq_val,
   output logic        memreq_rdy,
   output logic [44:0] memresp_msg,
   output logic        memresp_val,
   input  logic        memresp_rdy,
   input  logic        sd
);

   localparam int unsigned AW = $clog2(p_nwords);
   localparam int unsigned PW = $clog2(p_nentries);
   localparam int unsigned CW = PW + 2;
   localparam int unsigned NW = 2 * p_nwords;

   logic          r_valid_q, r_valid_d;
   logic [76:0]   r_msg_q, r_msg_d;
   logic          r_sd_q, r_sd_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic [31:0]   mem_q      [NW];
   logic [44:0]   fifo_msg_q [p_nentries];
   logic          fifo_sd_q  [p_nentries];

   logic [2:0]    r_type_c;
   logic [7:0]    r_opaque_c;
   logic [31:0]   r_addr_c;
   logic [1:0]    r_len_c;
   logic [31:0]   r_data_c;
   logic [1:0]    off_c;
   logic [AW:0]   idx_c;
   logic          is_wr_c;
   logic [3:0]    lane_mask_c;
   logic [3:0]    sel_mask_c;
   logic [31:0]   rd_word_c;
   logic [31:0]   rd_shift_c;
   logic [31:0]   rd_data_c;
   logic [31:0]   wr_shift_c;
   logic [31:0]   wr_word_c;
   logic [44:0]   resp_c;
   logic          push_c;
   logic          pop_c;
   logic          accept_c;
   logic [CW-1:0] occ_c;
   logic          unused_addr_c;

   assign r_type_c   = r_msg_q[76:74];
   assign r_opaque_c = r_msg_q[73:66];
   assign r_addr_c   = r_msg_q[65:34];
   assign r_len_c    = r_msg_q[33:32];
   assign r_data_c   = r_msg_q[31:0];
   assign off_c      = r_addr_c[1:0];
   assign idx_c      = {r_sd_q, r_addr_c[AW+1:2]};
   assign is_wr_c    = (r_type_c == 3'd1);
   assign unused_addr_c = ^r_addr_c[31:AW+2];

   // Byte-lane datapath: lanes past byte 3 fall off the shifts and are never wrapped.
   always_comb begin
      lane_mask_c = 4'hF;
      case (r_len_c)
         2'd1:    lane_mask_c = 4'h1;
         2'd2:    lane_mask_c = 4'h3;
         2'd3:    lane_mask_c = 4'h7;
         default: lane_mask_c = 4'hF;
      endcase
      sel_mask_c = lane_mask_c << off_c;
      rd_word_c  = mem_q[idx_c];
      rd_shift_c = rd_word_c >> {off_c, 3'b000};
      wr_shift_c = r_data_c << {off_c, 3'b000};
      rd_data_c  = '0;
      wr_word_c  = rd_word_c;
      for (int j = 0; j < 4; j++) begin
         if (lane_mask_c[j]) rd_data_c[8*j +: 8] = rd_shift_c[8*j +: 8];
         if (sel_mask_c[j])  wr_word_c[8*j +: 8] = wr_shift_c[8*j +: 8];
      end
      resp_c = {r_type_c, r_opaque_c, r_len_c, is_wr_c ? 32'd0 : rd_data_c};
   end

   // Head is only visible to its own domain; message is forced to zero otherwise.
   assign memresp_val = (count_q != '0) && (fifo_sd_q[head_q] == sd);
   assign memresp_msg = memresp_val ? fifo_msg_q[head_q] : 45'd0;

   assign push_c   = r_valid_q;
   assign pop_c    = memresp_val && memresp_rdy;
   assign occ_c    = CW'(r_valid_q) + count_q;
   assign memreq_rdy = !reset && ((occ_c < CW'(p_nentries)) ||
                                  ((occ_c == CW'(p_nentries)) && pop_c));
   assign accept_c = memreq_val && memreq_rdy;

   always_comb begin
      r_valid_d = accept_c;
      r_msg_d   = r_msg_q;
      r_sd_d    = r_sd_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q + CW'(push_c) - CW'(pop_c);
      if (accept_c) begin
         r_msg_d = memreq_msg;
         r_sd_d  = sd;
      end
      if (push_c) tail_d = tail_q + PW'(1);
      if (pop_c)  head_d = head_q + PW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid_q <= 1'b0;
         r_msg_q   <= '0;
         r_sd_q    <= 1'b0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         r_valid_q <= r_valid_d;
         r_msg_q   <= r_msg_d;
         r_sd_q    <= r_sd_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   // Storage arrays carry no reset; validity is tracked by the control registers above.
   always_ff @(posedge clk) begin
      if (push_c) begin
         fifo_msg_q[tail_q] <= resp_c;
         fifo_sd_q[tail_q]  <= r_sd_q;
      end
      if (push_c && is_wr_c) mem_q[idx_c] <= wr_word_c;
   end

endmodule
